// File: rtl/limb_pkg.sv
// Shared types and constants for the LIMB host port to Wishbone bridge.
// Holds the frame FSM encoding and the per-frame byte counts.
// Pure declarations: no logic, no latency, no backpressure.
package limb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WB    = 3'd3,
    ST_RDATA = 3'd4
  } limb_state_t;

  localparam int unsigned HDR_BYTES  = 1;
  localparam int unsigned ADDR_BYTES = 4;
  localparam int unsigned DATA_BYTES = 4;

  // Index of the final byte within a field, as seen by the 2-bit byte counter.
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

endpackage

// File: rtl/limb_strobe_sync.sv
// Brings the asynchronous host byte strobe into clk and detects its rising edge.
// Latency: pulse is high in the cycle after the 2nd sampling edge, consumed on the 3rd.
// Backpressure: none; the host guarantees the minimum high/low strobe widths.
module limb_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic limb_clk,
  output logic strobe
);

  logic sync_q1;
  logic sync_q2;
  logic hist_q;

  // two-flop synchronizer followed by a history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync_q1 <= limb_clk;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
    end
  end

  assign strobe = sync_q2 & ~hist_q;

endmodule

// File: rtl/limb_wb_bridge.sv
// Byte-serial LIMB host frames -> single 32-bit Wishbone classic read/write; read data returned bytewise.
// Latency: cyc/stb one clock after the last frame byte event; idle again one clock after wb_ack_i.
// Backpressure: limb_nwait low while the Wishbone cycle is open. LIMB_ADDR_AUTOINC_EN adds address-increment bursts.
import limb_pkg::*;

module limb_wb_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  limb_d_in,
  output logic [7:0]  limb_d_out,
  output logic        limb_d_oe,
  input  logic        limb_clk,
  input  logic        limb_nrd,
  input  logic        limb_start,
  output logic        limb_nwait,
  output logic [35:0] wb_adr_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  limb_state_t state_q, state_d;
  logic        strobe;
  logic        hdr_evt;
  logic        byte_evt;
  logic        in_wb;
  logic [1:0]  cnt_q;
  logic [35:0] adr_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
`ifdef LIMB_ADDR_AUTOINC_EN
  logic        burst_ok_q;
`endif

  limb_strobe_sync u_strobe_sync (
    .clk      (clk),
    .reset    (reset),
    .limb_clk (limb_clk),
    .strobe   (strobe)
  );

  // A header restarts the frame from any state except an open bus cycle.
  assign hdr_evt  = strobe & limb_start & (state_q != ST_WB);
  assign byte_evt = strobe & ~limb_start;
  assign in_wb    = (state_q == ST_WB);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state: header, byte counting, bus completion, read-byte drain
  always_comb begin
    state_d = state_q;
    if (hdr_evt) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef LIMB_ADDR_AUTOINC_EN
          if (byte_evt && burst_ok_q) state_d = we_q ? ST_WDATA : ST_WB;
`endif
        end
        ST_ADDR:  if (byte_evt && cnt_q == ADDR_LAST) state_d = we_q ? ST_WDATA : ST_WB;
        ST_WDATA: if (byte_evt && cnt_q == DATA_LAST) state_d = ST_WB;
        ST_WB:    if (wb_ack_i) state_d = we_q ? ST_IDLE : ST_RDATA;
        ST_RDATA: if (byte_evt && cnt_q == DATA_LAST) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // frame datapath: header/address/data capture, read latch and read shift-out
  // (the 2-bit counter wraps back to 0 after the 4th byte of each field)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 2'd0;
      adr_q      <= 36'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
`ifdef LIMB_ADDR_AUTOINC_EN
      burst_ok_q <= 1'b0;
`endif
    end else if (hdr_evt) begin
      adr_q      <= {limb_d_in[7:4], 32'd0};
      sel_q      <= limb_d_in[3:0];
      we_q       <= limb_nrd;
      cnt_q      <= 2'd0;
`ifdef LIMB_ADDR_AUTOINC_EN
      burst_ok_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef LIMB_ADDR_AUTOINC_EN
          // burst continuation: a write burst's first strobe already carries data byte 0
          if (byte_evt && burst_ok_q) begin
            adr_q <= adr_q + 36'd1;
            if (we_q) begin
              wdata_q <= {wdata_q[23:0], limb_d_in};
              cnt_q   <= 2'd1;
            end else begin
              cnt_q   <= 2'd0;
            end
          end
`endif
        end
        ST_ADDR: begin
          if (byte_evt) begin
            adr_q[31:0] <= {adr_q[23:0], limb_d_in};
            cnt_q       <= cnt_q + 2'd1;
          end
        end
        ST_WDATA: begin
          if (byte_evt) begin
            wdata_q <= {wdata_q[23:0], limb_d_in};
            cnt_q   <= cnt_q + 2'd1;
          end
        end
        ST_WB: begin
          if (wb_ack_i) begin
            if (!we_q) rdata_q <= wb_dat_i;
`ifdef LIMB_ADDR_AUTOINC_EN
            else burst_ok_q <= 1'b1;
`endif
          end
        end
        ST_RDATA: begin
          if (byte_evt) begin
            rdata_q <= {rdata_q[23:0], 8'h00};
            cnt_q   <= cnt_q + 2'd1;
`ifdef LIMB_ADDR_AUTOINC_EN
            if (cnt_q == DATA_LAST) burst_ok_q <= 1'b1;
`endif
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  // Bus outputs are zero outside the cycle so reset and idle look identical.
  assign wb_cyc_o   = in_wb;
  assign wb_stb_o   = in_wb;
  assign wb_adr_o   = in_wb ? adr_q : 36'd0;
  assign wb_sel_o   = in_wb ? sel_q : 4'd0;
  assign wb_we_o    = in_wb & we_q;
  assign wb_dat_o   = (in_wb && we_q) ? wdata_q : 32'd0;

  assign limb_d_oe  = (state_q == ST_RDATA);
  assign limb_d_out = limb_d_oe ? rdata_q[31:24] : 8'h00;
  assign limb_nwait = ~in_wb;

endmodule

// File: tb/tb_limb_wb_bridge.sv
// Randomized scoreboard bench for limb_wb_bridge with a word-memory reference model.
// Latency: host strobes are paced at 5 clk high / 5 clk low; slave acks after 0..3 wait cycles.
// Backpressure: the host waits on limb_nwait before every strobe, bounded by a cycle budget.
module tb_limb_wb_bridge;

  typedef struct {
    logic [35:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  limb_d_in;
  logic [7:0]  limb_d_out;
  logic        limb_d_oe;
  logic        limb_clk;
  logic        limb_nrd;
  logic        limb_start;
  logic        limb_nwait;
  logic [35:0] wb_adr_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  int wb_seen = 0;
  int wb_expected = 0;
  logic hold_ack = 1'b0;

  wb_exp_t     exp_wb[$];
  logic [7:0]  exp_byte[$];
  logic [31:0] model_mem[logic [35:0]];
  logic [31:0] slave_mem[logic [35:0]];

  limb_wb_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .limb_d_in  (limb_d_in),
    .limb_d_out (limb_d_out),
    .limb_d_oe  (limb_d_oe),
    .limb_clk   (limb_clk),
    .limb_nrd   (limb_nrd),
    .limb_start (limb_start),
    .limb_nwait (limb_nwait),
    .wb_adr_o   (wb_adr_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference model: a word memory with byte-lane masked writes.
  function automatic logic [31:0] model_rd(input logic [35:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 32'd0;
  endfunction

  task automatic model_wr(input logic [35:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] mask;
    mask = 32'd0;
    for (int i = 0; i < 4; i++) if (sel[i]) mask = mask | (32'hFF << (8 * i));
    model_mem[a] = (model_rd(a) & ~mask) | (d & mask);
  endtask

  task automatic wait_ready(input string who);
    int budget;
    budget = 300;
    while (limb_nwait !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_nwait_timeout: nwait=%b required 1 within 300 cycles", who, limb_nwait);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input logic start, input logic nrd);
    wait_ready("strobe");
    @(negedge clk);
    limb_d_in  = d;
    limb_start = start;
    limb_nrd   = nrd;
    limb_clk   = 1'b1;
    repeat (5) @(negedge clk);
    limb_clk   = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_hdr_adr(input logic [35:0] a, input logic [3:0] sel, input logic nrd);
    logic [31:0] lo;
    lo = a[31:0];
    strobe({a[35:32], sel}, 1'b1, nrd);
    for (int i = 3; i >= 0; i--) strobe(lo[8*i +: 8], 1'b0, nrd);
  endtask

  task automatic do_write(input logic [35:0] a, input logic [3:0] sel, input logic [31:0] d,
                          input bit commit);
    wb_exp_t e;
    e.adr = a; e.we = 1'b1; e.sel = sel; e.dat = d;
    exp_wb.push_back(e);
    wb_expected++;
    if (commit) model_wr(a, sel, d);
    send_hdr_adr(a, sel, 1'b1);
    for (int i = 3; i >= 0; i--) strobe(d[8*i +: 8], 1'b0, 1'b1);
  endtask

  task automatic do_read(input logic [35:0] a, input logic [3:0] sel);
    wb_exp_t e;
    logic [31:0] w;
    e.adr = a; e.we = 1'b0; e.sel = sel; e.dat = 32'd0;
    exp_wb.push_back(e);
    wb_expected++;
    w = model_rd(a);
    for (int i = 3; i >= 0; i--) exp_byte.push_back(w[8*i +: 8]);
    send_hdr_adr(a, sel, 1'b0);
    for (int i = 0; i < 4; i++) strobe(8'h00, 1'b0, 1'b0);
    check("rd_oe_after_4th", {63'd0, limb_d_oe}, 64'd0);
    check("rd_nwait_after_4th", {63'd0, limb_nwait}, 64'd1);
  endtask

  // Wishbone slave: word memory with random ack latency, ack can be withheld.
  initial begin
    int lat;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'd0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wb_ack_i = 1'b0;
        lat = $urandom_range(0, 3);
      end else if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        lat = $urandom_range(0, 3);
      end else if (wb_cyc_o && wb_stb_o && !hold_ack) begin
        if (lat == 0) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            logic [31:0] w;
            w = slave_mem.exists(wb_adr_o) ? slave_mem[wb_adr_o] : 32'd0;
            for (int i = 0; i < 4; i++) if (wb_sel_o[i]) w[8*i +: 8] = wb_dat_o[8*i +: 8];
            slave_mem[wb_adr_o] = w;
          end else begin
            wb_dat_i = slave_mem.exists(wb_adr_o) ? slave_mem[wb_adr_o] : 32'd0;
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // Bus monitor: each new cycle is matched against the next expected transaction.
  initial begin
    logic prev_cyc;
    wb_exp_t e;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o && !prev_cyc) begin
        wb_seen++;
        if (exp_wb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: adr=%h we=%b with no cycle expected", wb_adr_o, wb_we_o);
        end else begin
          e = exp_wb.pop_front();
          check("wb_adr", {28'd0, wb_adr_o}, {28'd0, e.adr});
          check("wb_we", {63'd0, wb_we_o}, {63'd0, e.we});
          check("wb_sel", {60'd0, wb_sel_o}, {60'd0, e.sel});
          check("wb_stb", {63'd0, wb_stb_o}, 64'd1);
          check("wb_nwait_busy", {63'd0, limb_nwait}, 64'd0);
          if (e.we) check("wb_dat", {32'd0, wb_dat_o}, {32'd0, e.dat});
        end
      end
      prev_cyc = wb_cyc_o;
    end
  end

  // Read-byte monitor: the byte the host captures on each strobe rise.
  initial begin
    forever begin
      @(posedge limb_clk);
      if (limb_d_oe) begin
        if (exp_byte.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_byte_unexpected: got %h with no byte expected", limb_d_out);
        end else begin
          check("rd_byte", {56'd0, limb_d_out}, {56'd0, exp_byte.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    reset      = 1'b1;
    limb_d_in  = 8'h00;
    limb_clk   = 1'b0;
    limb_nrd   = 1'b1;
    limb_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    check("rst_stb", {63'd0, wb_stb_o}, 64'd0);
    check("rst_we", {63'd0, wb_we_o}, 64'd0);
    check("rst_adr", {28'd0, wb_adr_o}, 64'd0);
    check("rst_sel", {60'd0, wb_sel_o}, 64'd0);
    check("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    check("rst_d_out", {56'd0, limb_d_out}, 64'd0);
    check("rst_oe", {63'd0, limb_d_oe}, 64'd0);
    check("rst_nwait", {63'd0, limb_nwait}, 64'd1);

    // full-word write, read back, byte-select write, read back merged word
    do_write(36'd3, 4'hF, 32'hDEADBEEF, 1'b1);
    do_read(36'd3, 4'hF);
    do_write(36'd3, 4'h3, 32'h11223344, 1'b1);
    do_read(36'd3, 4'hF);

    // aborted frame: header plus two address bytes, then a fresh write frame
    strobe(8'h0F, 1'b1, 1'b1);
    strobe(8'h00, 1'b0, 1'b1);
    strobe(8'h00, 1'b0, 1'b1);
    do_write(36'd5, 4'hF, 32'h01020304, 1'b1);
    do_read(36'd5, 4'hF);

    // reset while the slave withholds ack
    hold_ack = 1'b1;
    do_write(36'd9, 4'hF, 32'h55AA55AA, 1'b0);
    budget = 100;
    while (!wb_cyc_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_wb_cyc_open", {63'd0, wb_cyc_o}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_wb_rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    check("mid_wb_rst_stb", {63'd0, wb_stb_o}, 64'd0);
    check("mid_wb_rst_nwait", {63'd0, limb_nwait}, 64'd1);
    reset = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    do_read(36'd9, 4'hF);
    do_write(36'd9, 4'hF, 32'hCAFEF00D, 1'b1);
    do_read(36'd9, 4'hF);

`ifdef LIMB_ADDR_AUTOINC_EN
    // burst: a completed write followed by four continuation strobes
    begin
      wb_exp_t e;
      do_write(36'd7, 4'hF, 32'h12345678, 1'b1);
      e.adr = 36'd8; e.we = 1'b1; e.sel = 4'hF; e.dat = 32'hAABBCCDD;
      exp_wb.push_back(e);
      wb_expected++;
      model_wr(36'd8, 4'hF, 32'hAABBCCDD);
      strobe(8'hAA, 1'b0, 1'b1);
      strobe(8'hBB, 1'b0, 1'b1);
      strobe(8'hCC, 1'b0, 1'b1);
      strobe(8'hDD, 1'b0, 1'b1);
      do_read(36'd8, 4'hF);
    end
`else
    // stray data strobe while idle must not start anything
    strobe(8'h5A, 1'b0, 1'b1);
    strobe(8'hA5, 1'b0, 1'b0);
`endif

    // randomized frames over a small address set, including a high nibble
    for (int n = 0; n < 12; n++) begin
      logic [35:0] a;
      logic [3:0]  s;
      a = {($urandom_range(0, 1) == 1) ? 4'hA : 4'h0, 32'($urandom_range(0, 7))};
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, s, $urandom, 1'b1);
      else do_read(a, s);
    end

    wait_ready("final");
    repeat (10) @(negedge clk);
    check("wb_cycle_count", 64'(wb_seen), 64'(wb_expected));
    check("wb_queue_empty", 64'(exp_wb.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_byte.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
